// File: rtl/vga_plot_pkg.sv
// Shared constants, FSM state type and clipping helper for the VGA plot arbiter.
package vga_plot_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int X_W          = 8;
  localparam int Y_W          = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counters are one bit wider than the port so x0+w / y0+h never wrap.
  function automatic logic on_screen(input logic [X_W:0] px, input logic [Y_W:0] py,
                                     input int unsigned scr_w, input int unsigned scr_h);
    return (32'(px) < scr_w) && (32'(py) < scr_h);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot arbiter: round-robin from ptr_i, or lowest-index-wins
// when VGA_PLOT_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

`ifdef VGA_PLOT_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_i[i] && (gnt_o == '0)) gnt_o[i] = 1'b1;
    end
  end
`else
  int unsigned idx;

  always_comb begin
    gnt_o = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr_i) + k) % NUM_REQ;
      if (req_i[idx] && (gnt_o == '0)) gnt_o[idx] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the VGA adapter pixel port among NUM_REQ rectangle-fill clients.
// Define VGA_PLOT_ARB_FIXED_PRIO_EN for fixed (lowest index) priority.
module vga_plot_arbiter
  import vga_plot_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int COLOR_W  = 3
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       rect_x0,
  input  logic [7*NUM_REQ-1:0]       rect_y0,
  input  logic [8*NUM_REQ-1:0]       rect_w,
  input  logic [7*NUM_REQ-1:0]       rect_h,
  input  logic [COLOR_W*NUM_REQ-1:0] rect_color,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic [X_W-1:0]             x,
  output logic [Y_W-1:0]             y,
  output logic [COLOR_W-1:0]         colour,
  output logic                       plot
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [X_W:0]         x_q, x_d, x0_q, x0_d, xe_q, xe_d;
  logic [Y_W:0]         y_q, y_d, ye_q, ye_d;
  logic [COLOR_W-1:0]   col_q, col_d;
  logic                 plot_q, plot_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [PTR_W-1:0]     arb_ptr;
  logic [X_W-1:0]       sel_x0;
  logic [Y_W-1:0]       sel_y0;
  logic [7:0]           sel_w;
  logic [6:0]           sel_h;
  logic [COLOR_W-1:0]   sel_col;
  logic [X_W:0]         sel_x0_ext, x_inc;
  logic [Y_W:0]         sel_y0_ext, y_inc;

`ifdef VGA_PLOT_ARB_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [PTR_W-1:0] ptr_q, ptr_d, win_idx;

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) win_idx = PTR_W'(i);
    end
  end

  assign arb_ptr = ptr_q;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req_i (req),
    .ptr_i (arb_ptr),
    .gnt_o (arb_gnt)
  );

  always_comb begin
    sel_x0  = '0;
    sel_y0  = '0;
    sel_w   = '0;
    sel_h   = '0;
    sel_col = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_x0  = rect_x0[8*i +: 8];
        sel_y0  = rect_y0[7*i +: 7];
        sel_w   = rect_w[8*i +: 8];
        sel_h   = rect_h[7*i +: 7];
        sel_col = rect_color[COLOR_W*i +: COLOR_W];
      end
    end
  end

  assign sel_x0_ext = {1'b0, sel_x0};
  assign sel_y0_ext = {1'b0, sel_y0};
  assign x_inc      = x_q + 9'd1;
  assign y_inc      = y_q + 8'd1;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    x_d     = x_q;
    y_d     = y_q;
    x0_d    = x0_q;
    xe_d    = xe_q;
    ye_d    = ye_q;
    col_d   = col_q;
    plot_d  = 1'b0;
`ifndef VGA_PLOT_ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (|req) begin
          gnt_d = arb_gnt;
          x0_d  = sel_x0_ext;
          x_d   = sel_x0_ext;
          y_d   = sel_y0_ext;
          xe_d  = sel_x0_ext + {1'b0, sel_w} - 9'd1;
          ye_d  = sel_y0_ext + {1'b0, sel_h} - 8'd1;
          col_d = sel_col;
`ifndef VGA_PLOT_ARB_FIXED_PRIO_EN
          ptr_d = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PTR_W'(1);
`endif
          if ((sel_w == '0) || (sel_h == '0)) begin
            state_d = DONE;
            done_d  = arb_gnt;
          end else begin
            state_d = DRAW;
            plot_d  = on_screen(sel_x0_ext, sel_y0_ext, SCREEN_W, SCREEN_H);
          end
        end
      end
      // x_q/y_q hold the pixel being presented; plot_d is for the next one.
      DRAW: begin
        if (x_q == xe_q) begin
          if (y_q == ye_q) begin
            state_d = DONE;
            done_d  = gnt_q;
          end else begin
            x_d    = x0_q;
            y_d    = y_inc;
            plot_d = on_screen(x0_q, y_inc, SCREEN_W, SCREEN_H);
          end
        end else begin
          x_d    = x_inc;
          plot_d = on_screen(x_inc, y_q, SCREEN_W, SCREEN_H);
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      x0_q    <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      col_q   <= '0;
      plot_q  <= 1'b0;
`ifndef VGA_PLOT_ARB_FIXED_PRIO_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      x_q     <= x_d;
      y_q     <= y_d;
      x0_q    <= x0_d;
      xe_q    <= xe_d;
      ye_q    <= ye_d;
      col_q   <= col_d;
      plot_q  <= plot_d;
`ifndef VGA_PLOT_ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign busy   = (state_q == DRAW) || (state_q == DONE);
  assign x      = x_q[X_W-1:0];
  assign y      = y_q[Y_W-1:0];
  assign colour = col_q;
  assign plot   = plot_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: pixel-index reference model, directed fills, random traffic.
module tb_vga_plot_arbiter;

  localparam int N  = 3;
  localparam int CW = 3;
  localparam int SW = 160;
  localparam int SH = 120;

  logic            clk = 1'b0;
  logic            resetn;
  logic [N-1:0]    req;
  logic [8*N-1:0]  rect_x0;
  logic [7*N-1:0]  rect_y0;
  logic [8*N-1:0]  rect_w;
  logic [7*N-1:0]  rect_h;
  logic [CW*N-1:0] rect_color;
  logic [N-1:0]    gnt, done;
  logic            busy, plot;
  logic [7:0]      x;
  logic [6:0]      y;
  logic [CW-1:0]   colour;

  vga_plot_arbiter #(.NUM_REQ(N), .SCREEN_W(SW), .SCREEN_H(SH), .COLOR_W(CW)) dut (
    .clk(clk), .resetn(resetn), .req(req), .rect_x0(rect_x0), .rect_y0(rect_y0),
    .rect_w(rect_w), .rect_h(rect_h), .rect_color(rect_color), .gnt(gnt), .done(done),
    .busy(busy), .x(x), .y(y), .colour(colour), .plot(plot)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  logic [17:0] plot_log[$];
  int          done_log[$];
  int          busy_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a fill is just "pixel index idx of w*h", position by div/mod.
  int m_phase = 0, m_owner = 0, m_ptr = 0, m_idx = 0, m_total = 0;
  int m_x0 = 0, m_y0 = 0, m_w = 0, m_h = 0, m_col = 0;

  always @(posedge clk) begin
    int win;
    if (!resetn) begin
      m_phase = 0;
      m_ptr   = 0;
    end else begin
      case (m_phase)
        0: if (req != '0) begin
          win = -1;
          for (int k = 0; k < N; k++) begin
`ifdef VGA_PLOT_ARB_FIXED_PRIO_EN
            if (win < 0 && req[k]) win = k;
`else
            if (win < 0 && req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
`endif
          end
          m_owner = win;
          m_x0    = int'(rect_x0[8*win +: 8]);
          m_y0    = int'(rect_y0[7*win +: 7]);
          m_w     = int'(rect_w[8*win +: 8]);
          m_h     = int'(rect_h[7*win +: 7]);
          m_col   = int'(rect_color[CW*win +: CW]);
          m_ptr   = (win + 1) % N;
          m_total = m_w * m_h;
          m_idx   = 0;
          m_phase = (m_total == 0) ? 2 : 1;
        end
        1: begin
          m_idx++;
          if (m_idx == m_total) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] e_gnt, e_done;
    logic         e_plot;
    int           ex, ey;
    if (chk_en) begin
      e_gnt  = (m_phase != 0) ? N'(1) << m_owner : '0;
      e_done = (m_phase == 2) ? N'(1) << m_owner : '0;
      ex     = (m_phase == 1) ? m_x0 + m_idx % m_w : 0;
      ey     = (m_phase == 1) ? m_y0 + m_idx / m_w : 0;
      e_plot = (m_phase == 1) && (ex < SW) && (ey < SH);
      chk("gnt",  32'(gnt),  32'(e_gnt));
      chk("done", 32'(done), 32'(e_done));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("plot", 32'(plot), 32'(e_plot));
      if (e_plot) begin
        chk("x",      32'(x),      32'(ex));
        chk("y",      32'(y),      32'(ey));
        chk("colour", 32'(colour), 32'(m_col));
      end
    end
    if (plot) plot_log.push_back({x, y, colour});
    for (int i = 0; i < N; i++) if (done[i]) done_log.push_back(i);
    if (busy) busy_cnt++;
  end

  task automatic set_rect(input int i, input int x0, input int y0, input int w, input int h, input int c);
    rect_x0[8*i +: 8]     = 8'(x0);
    rect_y0[7*i +: 7]     = 7'(y0);
    rect_w[8*i +: 8]      = 8'(w);
    rect_h[7*i +: 7]      = 7'(h);
    rect_color[CW*i +: CW] = CW'(c);
  endtask

  task automatic clear_logs();
    plot_log.delete();
    done_log.delete();
    busy_cnt = 0;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_dones(input int n, input bit drop, input int max_cyc);
    int cyc = 0;
    while (done_log.size() < n && cyc < max_cyc) begin
      step();
      if (drop) req = req & ~done;
      cyc++;
    end
    chk("done_within_budget", 32'(done_log.size() >= n), 32'd1);
    if (!drop) req = '0;
    step();
    step();
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_gnt"},  32'(gnt), 0);
    chk({nm, "_done"}, 32'(done), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_plot"}, 32'(plot), 0);
    chk({nm, "_xyc"},  32'({x, y, colour}), 0);
  endtask

  initial begin
    resetn = 1'b0; req = '0;
    rect_x0 = '0; rect_y0 = '0; rect_w = '0; rect_h = '0; rect_color = '0;
    clear_logs();
    step();
    chk_en = 1;
    chk_all_zero("reset");
    resetn = 1'b1;

    // Simultaneous held requests, 1x1 each: rotation starts at client 0.
    for (int i = 0; i < N; i++) set_rect(i, 40 + i, 50, 1, 1, i + 1);
    clear_logs();
    req = 3'b111;
    wait_dones(4, 1'b0, 40);
`ifdef VGA_PLOT_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) chk("rr_order", 32'(done_log[k]), 0);
`else
    chk("rr_order0", 32'(done_log[0]), 0);
    chk("rr_order1", 32'(done_log[1]), 1);
    chk("rr_order2", 32'(done_log[2]), 2);
    chk("rr_order3", 32'(done_log[3]), 0);
`endif

    // 2x2 at (10,20), colour 4.
    set_rect(0, 10, 20, 2, 2, 4);
    clear_logs();
    req = 3'b001;
    wait_dones(1, 1'b1, 40);
    chk("t1_npix", 32'(plot_log.size()), 4);
    if (plot_log.size() == 4) begin
      chk("t1_p0", 32'(plot_log[0]), 32'({8'd10, 7'd20, 3'd4}));
      chk("t1_p1", 32'(plot_log[1]), 32'({8'd11, 7'd20, 3'd4}));
      chk("t1_p2", 32'(plot_log[2]), 32'({8'd10, 7'd21, 3'd4}));
      chk("t1_p3", 32'(plot_log[3]), 32'({8'd11, 7'd21, 3'd4}));
    end
    chk("t1_busy", 32'(busy_cnt), 5);
    chk("t1_done", 32'(done_log[0]), 0);

    // Corner clipping: only (158,119) and (159,119) are visible.
    set_rect(0, 158, 119, 4, 2, 7);
    clear_logs();
    req = 3'b001;
    wait_dones(1, 1'b1, 40);
    chk("t3_npix", 32'(plot_log.size()), 2);
    if (plot_log.size() == 2) begin
      chk("t3_p0", 32'(plot_log[0]), 32'({8'd158, 7'd119, 3'd7}));
      chk("t3_p1", 32'(plot_log[1]), 32'({8'd159, 7'd119, 3'd7}));
    end
    chk("t3_busy", 32'(busy_cnt), 9);

    // Zero width: straight to done.
    set_rect(2, 30, 30, 0, 5, 1);
    clear_logs();
    req = 3'b100;
    wait_dones(1, 1'b1, 20);
    chk("t4_npix", 32'(plot_log.size()), 0);
    chk("t4_busy", 32'(busy_cnt), 1);
    chk("t4_done", 32'(done_log[0]), 2);

    // Reset mid-fill abandons the fill and rewinds the pointer.
    set_rect(1, 5, 5, 10, 10, 3);
    clear_logs();
    req = 3'b010;
    repeat (20) step();
    resetn = 1'b0;
    req    = '0;
    step();
    chk_all_zero("t5_reset");
    resetn = 1'b1;
    repeat (3) step();
    chk("t5_nodone", 32'(done_log.size()), 0);
    for (int i = 0; i < N; i++) set_rect(i, 70 + i, 70, 1, 1, 6);
    clear_logs();
    req = 3'b111;
    wait_dones(3, 1'b1, 40);
    chk("t5_ptr0", 32'(done_log[0]), 0);
    chk("t5_ptr1", 32'(done_log[1]), 1);
    chk("t5_ptr2", 32'(done_log[2]), 2);

    // Client 1 withdraws and moves its rect mid-fill; latched values win.
    set_rect(1, 5, 6, 3, 2, 5);
    set_rect(2, 50, 60, 1, 1, 2);
    clear_logs();
    req = 3'b110;
    repeat (3) step();
    req[1] = 1'b0;
    rect_x0[15:8] = 8'd100;
    wait_dones(2, 1'b1, 40);
    chk("t6_done1", 32'(done_log[0]), 1);
    chk("t6_done2", 32'(done_log[1]), 2);
    chk("t6_npix", 32'(plot_log.size()), 7);
    if (plot_log.size() == 7) begin
      chk("t6_p0", 32'(plot_log[0]), 32'({8'd5, 7'd6, 3'd5}));
      chk("t6_p5", 32'(plot_log[5]), 32'({8'd7, 7'd7, 3'd5}));
      chk("t6_p6", 32'(plot_log[6]), 32'({8'd50, 7'd60, 3'd2}));
    end

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      step();
      resetn = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < N; i++) begin
        if (done[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) begin
          set_rect(i,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(150, 200) : $urandom_range(0, 255),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(110, 127) : $urandom_range(0, 127),
                   $urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 7));
          req[i] = 1'b1;
        end else if (req[i] && $urandom_range(0, 39) == 0) req[i] = 1'b0;
        if ($urandom_range(0, 7) == 0) begin
          rect_x0[8*i +: 8] = 8'($urandom_range(0, 255));
          rect_w[8*i +: 8]  = 8'($urandom_range(0, 5));
        end
      end
    end
    resetn = 1'b1;
    req    = '0;
    repeat (60) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
